// File: rtl/edge_reject.sv
// Edge-response rejection for DoG keypoint candidates: keeps a candidate only when its
// Hessian curvature ratio is below R_EDGE. Optional per-frame counters under EDGE_REJECT_STATS_EN.
module edge_reject #(
    parameter int R_EDGE = 10
) (
    input  logic               iclk,
    input  logic               irst_n,
    input  logic               ivalid,
    input  logic               icand,
    input  logic signed [9:0]  itr,
    input  logic signed [16:0] idet,
    input  logic [10:0]        ix,
    input  logic [10:0]        iy,
    input  logic               isof,
    output logic               ovalid,
    output logic               okeep,
    output logic [10:0]        ox,
    output logic [10:0]        oy
`ifdef EDGE_REJECT_STATS_EN
    ,
    output logic [15:0]        oacc_cnt,
    output logic [15:0]        orej_cnt
`endif
);

    localparam logic signed [27:0] K_DET = 28'((R_EDGE + 1) * (R_EDGE + 1));
    localparam logic signed [27:0] K_TR  = 28'(R_EDGE);

    // Valid shift register; bit 3 is the registered output valid.
    logic [3:1] r_vld;

    logic               r_cand1, r_cand2;
    logic [19:0]        r_tr_sq1;
    logic signed [27:0] r_det_sc1, r_det_sc2, r_lhs2;
    logic [10:0]        r_x1, r_y1, r_x2, r_y2;

    logic signed [19:0] w_tr_ext, w_tr_sq;
    logic signed [27:0] w_det_ext, w_det_sc, w_lhs;
    logic               w_keep;

    // itr^2 is at most 262144 (itr = -512), which fits a 20-bit signed product.
    assign w_tr_ext  = 20'(itr);
    assign w_tr_sq   = w_tr_ext * w_tr_ext;
    assign w_det_ext = 28'(idet);
    assign w_det_sc  = w_det_ext * K_DET;
    assign w_lhs     = $signed({8'd0, r_tr_sq1}) * K_TR;
    assign w_keep    = r_cand2 && (r_det_sc2 > 28'sd0) && (r_lhs2 < r_det_sc2);

    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            r_vld <= '0;
        end else begin
            r_vld <= {r_vld[2:1], ivalid};
        end
    end

    assign ovalid = r_vld[3];

    // Data registers only load behind a valid bit so idle inputs never disturb state.
    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            r_cand1   <= 1'b0;
            r_tr_sq1  <= '0;
            r_det_sc1 <= '0;
            r_x1      <= '0;
            r_y1      <= '0;
        end else if (ivalid) begin
            r_cand1   <= icand;
            r_tr_sq1  <= w_tr_sq;
            r_det_sc1 <= w_det_sc;
            r_x1      <= ix;
            r_y1      <= iy;
        end
    end

    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            r_cand2   <= 1'b0;
            r_lhs2    <= '0;
            r_det_sc2 <= '0;
            r_x2      <= '0;
            r_y2      <= '0;
        end else if (r_vld[1]) begin
            r_cand2   <= r_cand1;
            r_lhs2    <= w_lhs;
            r_det_sc2 <= r_det_sc1;
            r_x2      <= r_x1;
            r_y2      <= r_y1;
        end
    end

    logic r_ocand;

    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            okeep   <= 1'b0;
            ox      <= '0;
            oy      <= '0;
            r_ocand <= 1'b0;
        end else if (r_vld[2]) begin
            okeep   <= w_keep;
            ox      <= r_x2;
            oy      <= r_y2;
            r_ocand <= r_cand2;
        end
    end

`ifdef EDGE_REJECT_STATS_EN
    logic w_cnt_ev, w_acc_ev, w_rej_ev;

    // A result is counted in the cycle it is presented on ovalid; isof in that
    // same cycle restarts the frame with this result as its first count.
    assign w_cnt_ev = ovalid && r_ocand;
    assign w_acc_ev = w_cnt_ev && okeep;
    assign w_rej_ev = w_cnt_ev && !okeep;

    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            oacc_cnt <= '0;
            orej_cnt <= '0;
        end else if (isof) begin
            oacc_cnt <= w_acc_ev ? 16'd1 : 16'd0;
            orej_cnt <= w_rej_ev ? 16'd1 : 16'd0;
        end else begin
            if (w_acc_ev && oacc_cnt != 16'hFFFF) oacc_cnt <= oacc_cnt + 16'd1;
            if (w_rej_ev && orej_cnt != 16'hFFFF) orej_cnt <= orej_cnt + 16'd1;
        end
    end
`else
    logic w_unused;
    assign w_unused = isof ^ r_ocand;
`endif

endmodule

// File: tb/tb_edge_reject.sv
// Directed bench for edge_reject (R_EDGE=10): latency, edge-test boundaries, streaming,
// reset flush, and the per-frame counters when EDGE_REJECT_STATS_EN is defined.
module tb_edge_reject;

    logic               iclk = 1'b0;
    logic               irst_n = 1'b0;
    logic               ivalid = 1'b0;
    logic               icand = 1'b0;
    logic signed [9:0]  itr = '0;
    logic signed [16:0] idet = '0;
    logic [10:0]        ix = '0;
    logic [10:0]        iy = '0;
    logic               isof = 1'b0;
    logic               ovalid, okeep;
    logic [10:0]        ox, oy;
`ifdef EDGE_REJECT_STATS_EN
    logic [15:0]        oacc_cnt, orej_cnt;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    edge_reject #(.R_EDGE(10)) dut (
        .iclk(iclk), .irst_n(irst_n), .ivalid(ivalid), .icand(icand),
        .itr(itr), .idet(idet), .ix(ix), .iy(iy), .isof(isof),
        .ovalid(ovalid), .okeep(okeep), .ox(ox), .oy(oy)
`ifdef EDGE_REJECT_STATS_EN
        , .oacc_cnt(oacc_cnt), .orej_cnt(orej_cnt)
`endif
    );

    always #5 iclk = ~iclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One isolated sample: checks 3-cycle latency, result, and hold afterwards.
    task automatic single(input string tag, input logic c, input int tr, input int det,
                          input logic [10:0] x, input logic [10:0] y, input logic ek);
        @(negedge iclk);
        ivalid = 1'b1; icand = c; itr = 10'(tr); idet = 17'(det); ix = x; iy = y;
        @(negedge iclk);
        ivalid = 1'b0; icand = ~c; itr = ~itr; idet = ~idet; ix = ~x; iy = ~y;
        @(posedge iclk); #1;
        chk({tag, "_early"}, 32'(ovalid), 32'd0);
        @(posedge iclk); #1;
        chk({tag, "_ovalid"}, 32'(ovalid), 32'd1);
        chk({tag, "_okeep"}, 32'(okeep), 32'(ek));
        chk({tag, "_ox"}, 32'(ox), 32'(x));
        chk({tag, "_oy"}, 32'(oy), 32'(y));
        @(posedge iclk); #1;
        chk({tag, "_drop"}, 32'(ovalid), 32'd0);
        chk({tag, "_holdx"}, 32'(ox), 32'(x));
        chk({tag, "_holdk"}, 32'(okeep), 32'(ek));
    endtask

    task automatic sof_idle();
        @(negedge iclk); isof = 1'b1;
        @(negedge iclk); isof = 1'b0;
    endtask

    initial begin
        int nv;
        #12;
        chk("rst_ovalid", 32'(ovalid), 32'd0);
        chk("rst_okeep", 32'(okeep), 32'd0);
        chk("rst_ox", 32'(ox), 32'd0);
`ifdef EDGE_REJECT_STATS_EN
        chk("rst_acc", 32'(oacc_cnt), 32'd0);
        chk("rst_rej", 32'(orej_cnt), 32'd0);
`endif
        @(negedge iclk); irst_n = 1'b1;

        single("basic",   1'b1,   20,    50, 11'd5,    11'd7,    1'b1);
        single("over",    1'b1,   40,   100, 11'd12,   11'd34,   1'b0);
        single("equal",   1'b1,  110,  1000, 11'd2047, 11'd0,    1'b0);
        single("above",   1'b1,  110,  1001, 11'd100,  11'd200,  1'b1);
        single("det0",    1'b1,    0,     0, 11'd1,    11'd2,    1'b0);
        single("detneg",  1'b1,    0,    -5, 11'd3,    11'd4,    1'b0);
        single("detmin",  1'b1,    0, -65536, 11'd9,   11'd9,    1'b0);
        single("trmin",   1'b1, -512, 65535, 11'd1024, 11'd1023, 1'b1);
        single("nocand",  1'b0,   20,    50, 11'd77,   11'd88,   1'b0);

        // Eight back-to-back samples, candidates on even indices only.
        sof_idle();
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    @(negedge iclk);
                    ivalid = 1'b1; icand = (i % 2 == 0);
                    itr = (i < 4) ? 10'sd20 : 10'sd40;
                    idet = (i < 4) ? 17'sd50 : 17'sd100;
                    ix = 11'(100 + i); iy = 11'(200 + i);
                end
                @(negedge iclk); ivalid = 1'b0;
            end
            begin
                @(negedge iclk);
                repeat (3) @(posedge iclk);
                for (int j = 0; j < 8; j++) begin
                    #1;
                    chk("strm_ovalid", 32'(ovalid), 32'd1);
                    chk("strm_okeep", 32'(okeep), (j == 0 || j == 2) ? 32'd1 : 32'd0);
                    chk("strm_ox", 32'(ox), 32'(100 + j));
                    @(posedge iclk);
                end
                #1;
                chk("strm_end", 32'(ovalid), 32'd0);
            end
        join
        repeat (2) @(posedge iclk); #1;
`ifdef EDGE_REJECT_STATS_EN
        chk("strm_acc", 32'(oacc_cnt), 32'd2);
        chk("strm_rej", 32'(orej_cnt), 32'd2);

        // Saturation: 65537 accepted candidates must clamp at FFFF.
        sof_idle();
        for (int k = 0; k < 65537; k++) begin
            @(negedge iclk);
            ivalid = 1'b1; icand = 1'b1; itr = 10'sd20; idet = 17'sd50;
        end
        @(negedge iclk); ivalid = 1'b0;
        repeat (5) @(posedge iclk); #1;
        chk("sat_acc", 32'(oacc_cnt), 32'hFFFF);
        chk("sat_rej", 32'(orej_cnt), 32'd0);

        // isof in the same cycle as an accepted result: new frame starts at 1.
        @(negedge iclk);
        ivalid = 1'b1; icand = 1'b1; itr = 10'sd20; idet = 17'sd50;
        @(negedge iclk); ivalid = 1'b0;
        repeat (2) @(posedge iclk); #1;
        chk("sof_ovalid", 32'(ovalid), 32'd1);
        isof = 1'b1;
        @(posedge iclk); #1;
        isof = 1'b0;
        chk("sof_acc", 32'(oacc_cnt), 32'd1);
        chk("sof_rej", 32'(orej_cnt), 32'd0);
`endif

        // Reset with two samples in flight: everything clears, nothing emerges.
        @(negedge iclk);
        ivalid = 1'b1; icand = 1'b1; itr = 10'sd20; idet = 17'sd50; ix = 11'd500; iy = 11'd600;
        @(negedge iclk);
        ix = 11'd501;
        @(negedge iclk); ivalid = 1'b0;
        #2 irst_n = 1'b0;
        #1;
        chk("rfl_ovalid", 32'(ovalid), 32'd0);
        chk("rfl_okeep", 32'(okeep), 32'd0);
        chk("rfl_ox", 32'(ox), 32'd0);
        chk("rfl_oy", 32'(oy), 32'd0);
`ifdef EDGE_REJECT_STATS_EN
        chk("rfl_acc", 32'(oacc_cnt), 32'd0);
`endif
        @(negedge iclk); irst_n = 1'b1;
        nv = 0;
        repeat (5) begin
            @(posedge iclk); #1;
            if (ovalid) nv++;
        end
        chk("rfl_noout", 32'(nv), 32'd0);
        single("postrst", 1'b1, 20, 50, 11'd33, 11'd44, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
